// File: rtl/iter_div_unit.sv
// iter_div_unit: radix-2 restoring divider for the HI/LO path; result_o = {remainder, quotient}.
// Latency WIDTH+1 edges (2 for divide-by-zero/early-out); busy_o stalls issue, annul_i aborts. Optional: ITER_DIV_EARLY_OUT_EN.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic               busy_q, busy_d, ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               a_neg, b_neg, accept, div_zero, early, q_bit;
    logic [WIDTH-1:0]   a_mag, b_mag, diff;
    logic [WIDTH:0]     part;

    assign a_neg    = signed_i & dividend_i[WIDTH-1];
    assign b_neg    = signed_i & divisor_i[WIDTH-1];
    assign a_mag    = a_neg ? -dividend_i : dividend_i;
    assign b_mag    = b_neg ? -divisor_i : divisor_i;
    assign div_zero = (divisor_i == '0);
    assign accept   = start_i & ~annul_i & ((state_q == IDLE) | (state_q == DONE));

`ifdef ITER_DIV_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // The remainder is always below the divisor, so the low WIDTH bits of the difference suffice.
    assign part  = {rem_q, quo_q[WIDTH-1]};
    assign q_bit = (part >= {1'b0, dvs_q});
    assign diff  = part[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? ((div_zero | early) ? BYZERO : RUN) : IDLE;
            RUN:        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            BYZERO:     state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (annul_i) state_d = IDLE;
    end

    always_comb begin
        busy_d   = (state_d == RUN) | (state_d == BYZERO);
        ready_d  = (state_q == DONE);
        result_d = result_q;
        if (state_q == DONE)
            result_d = {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};
    end

    // Divide-by-zero and early-out preload the final quotient/remainder and skip iteration.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            dvs_d = b_mag;
            cnt_d = '0;
            if (div_zero) begin
                quo_d     = '1;
                rem_d     = dividend_i;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else if (early) begin
                quo_d     = '0;
                rem_d     = a_mag;
                neg_quo_d = 1'b0;
                neg_rem_d = a_neg;
            end else begin
                quo_d     = a_mag;
                rem_d     = '0;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
            end
        end else if (state_q == RUN) begin
            rem_d = q_bit ? diff : part[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule
